// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V fetch front end.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HELD,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;

   function automatic if_id_t bubble(input logic [31:0] pc);
      return '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
   endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// Pipeline register between stages: write-enable hold, flush turns the slot into a NOP bubble.
module if_id_reg
   import riscv_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   we,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   if_id_t reg_q, reg_d;

   always_comb begin
      reg_d = reg_q;
      if (flush) begin
         reg_d = bubble(reg_q.pc);
      end else if (we) begin
         reg_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_q <= bubble('0);
      end else begin
         reg_q <= reg_d;
      end
   end

   assign q = reg_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, single-outstanding imem handshake, stall buffer and IF/ID register.
// Define FETCH_PERF_CNT_EN to add fetch/bubble performance counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_write,
   input  logic            if_id_write,
   input  logic            flush,
   input  logic [XLEN-1:0] jump_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_instr,
   output logic            if_id_valid,
   output logic            fetch_busy,
   output logic [31:0]     perf_fetch_count,
   output logic [31:0]     perf_bubble_count
);

   import riscv_pkg::*;

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   if_id_t       buf_q, buf_d;
   if_id_t       if_id_d, if_id_q;
   logic         deliver;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      buf_d    = buf_q;
      imem_req = 1'b0;
      deliver  = 1'b0;
      if_id_d  = bubble(if_id_q.pc);

      case (state_q)
         REQ: begin
            imem_req = pc_write & ~flush & ~rst;
            if (imem_req && imem_ready) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (if_id_write) begin
                  deliver = 1'b1;
                  if_id_d = '{pc: req_pc_q, instr: imem_rdata, valid: 1'b1};
                  state_d = REQ;
               end else begin
                  buf_d   = '{pc: req_pc_q, instr: imem_rdata, valid: 1'b1};
                  state_d = HELD;
               end
            end
         end
         HELD: begin
            if (if_id_write && buf_q.valid) begin
               deliver = 1'b1;
               if_id_d = buf_q;
               buf_d   = bubble('0);
               state_d = REQ;
            end
         end
         DROP: begin
            if (imem_rvalid) begin
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase

      // Flush overrides everything; an outstanding response still owed must be swallowed in DROP.
      if (flush) begin
         pc_d    = jump_target & ~32'h3;
         buf_d   = bubble('0);
         deliver = 1'b0;
         if_id_d = bubble(if_id_q.pc);
         state_d = ((state_q == WAIT || state_q == DROP) && !imem_rvalid) ? DROP : REQ;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         buf_q    <= bubble('0);
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         buf_q    <= buf_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .rst   (rst),
      .we    (if_id_write),
      .flush (flush),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   assign imem_addr   = pc_q;
   assign if_id_pc    = if_id_q.pc;
   assign if_id_instr = if_id_q.instr;
   assign if_id_valid = if_id_q.valid;
   assign fetch_busy  = (state_q == WAIT) || (state_q == DROP);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      fetch_cnt_d  = fetch_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (deliver) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else if (flush || if_id_write) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign perf_fetch_count  = fetch_cnt_q;
   assign perf_bubble_count = bubble_cnt_q;
`else
   assign perf_fetch_count  = '0;
   assign perf_bubble_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory responder, PC model and expected IF/ID queue.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, pc_write, if_id_write, flush;
   logic [31:0] jump_target;
   logic        imem_req, imem_ready, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] if_id_pc, if_id_instr;
   logic        if_id_valid, fetch_busy;
   logic [31:0] perf_fetch_count, perf_bubble_count;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC), .XLEN(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .pc_write          (pc_write),
      .if_id_write       (if_id_write),
      .flush             (flush),
      .jump_target       (jump_target),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ready        (imem_ready),
      .imem_rvalid       (imem_rvalid),
      .imem_rdata        (imem_rdata),
      .if_id_pc          (if_id_pc),
      .if_id_instr       (if_id_instr),
      .if_id_valid       (if_id_valid),
      .fetch_busy        (fetch_busy),
      .perf_fetch_count  (perf_fetch_count),
      .perf_bubble_count (perf_bubble_count)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;

   // memory responder state
   logic        out_valid = 1'b0;
   logic [31:0] out_addr  = '0;
   int          out_cnt   = 0;
   int          mem_delay = 1;
   logic        force_en  = 1'b0;
   logic [31:0] force_val = '0;

   // reference model state
   logic [31:0] exp_pc    = RST_PC;
   logic        drop_pend = 1'b0;
   logic [31:0] prev_pc, prev_instr;
   logic        prev_valid;
   int          n_fetch   = 0;
   int          n_bubble  = 0;
   logic        fired;
   logic [31:0] fired_addr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      logic        rv;
      logic [31:0] rd;
      logic        fire;
      exp_t        e;
      logic        exp_v;
      @(negedge clk);
      rv          = out_valid && (out_cnt == 0) && !rst;
      rd          = force_en ? force_val : (out_addr ^ 32'h1357_9BDF);
      imem_rvalid = rv;
      imem_rdata  = rd;
      imem_ready  = 1'b1;
      #1;
      fire       = imem_req & imem_ready;
      fired      = fire;
      if (rst) begin
         check_eq("req_in_rst", {31'd0, imem_req}, 32'd0);
      end else begin
         if (!pc_write || flush) check_eq("req_blocked", {31'd0, imem_req}, 32'd0);
         if (imem_req) check_eq("one_outstanding", {31'd0, out_valid}, 32'd0);
         if (fire) begin
            check_eq("imem_addr", imem_addr, exp_pc);
            fired_addr = imem_addr;
         end
         if (rv) begin
            if (flush || drop_pend) drop_pend = 1'b0;
            else sb.push_back('{pc: out_addr, instr: rd});
         end
         if (flush) begin
            sb.delete();
            if (out_valid && !rv) drop_pend = 1'b1;
            exp_pc = {jump_target[31:2], 2'b00};
         end else if (fire) begin
            exp_pc = exp_pc + 32'd4;
         end
      end
      if (rst) begin
         out_valid = 1'b0;
      end else begin
         if (rv) out_valid = 1'b0;
         else if (out_valid) out_cnt--;
         if (fire) begin
            out_valid = 1'b1;
            out_addr  = imem_addr;
            out_cnt   = mem_delay - 1;
         end
      end

      @(posedge clk);
      #1;
      if (rst) begin
         exp_pc    = RST_PC;
         drop_pend = 1'b0;
         sb.delete();
         n_fetch   = 0;
         n_bubble  = 0;
         check_eq("rst_ifid_pc", if_id_pc, 32'd0);
         check_eq("rst_ifid_instr", if_id_instr, NOP);
         check_eq("rst_ifid_valid", {31'd0, if_id_valid}, 32'd0);
      end else if (flush) begin
         check_eq("flush_valid", {31'd0, if_id_valid}, 32'd0);
         check_eq("flush_instr", if_id_instr, NOP);
         check_eq("flush_pc_kept", if_id_pc, prev_pc);
         n_bubble++;
      end else if (if_id_write) begin
         exp_v = (sb.size() > 0);
         check_eq("ifid_valid", {31'd0, if_id_valid}, {31'd0, exp_v});
         if (exp_v) begin
            e = sb.pop_front();
            check_eq("ifid_pc", if_id_pc, e.pc);
            check_eq("ifid_instr", if_id_instr, e.instr);
            n_fetch++;
         end else begin
            check_eq("bubble_instr", if_id_instr, NOP);
            check_eq("bubble_pc_kept", if_id_pc, prev_pc);
            n_bubble++;
         end
      end else begin
         check_eq("hold_pc", if_id_pc, prev_pc);
         check_eq("hold_instr", if_id_instr, prev_instr);
         check_eq("hold_valid", {31'd0, if_id_valid}, {31'd0, prev_valid});
      end
      prev_pc    = if_id_pc;
      prev_instr = if_id_instr;
      prev_valid = if_id_valid;
   endtask

   task automatic run_until_fire();
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (fired) break;
      end
      check_eq("fire_timeout", {31'd0, fired}, 32'd1);
   endtask

   task automatic flush_to(input logic [31:0] tgt);
      flush       = 1'b1;
      jump_target = tgt;
      cycle();
      flush       = 1'b0;
   endtask

   initial begin
      int n;
      rst         = 1'b1;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      flush       = 1'b0;
      jump_target = '0;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      prev_pc     = '0;
      prev_instr  = NOP;
      prev_valid  = 1'b0;

      cycle();
      cycle();
      rst = 1'b0;
      check_eq("rst_busy", {31'd0, fetch_busy}, 32'd0);

      // streaming: one request every two cycles
      n = 0;
      repeat (8) begin
         cycle();
         n += int'(fired);
      end
      check_eq("fire_rate", n, 32'd4);

      // decode stall while response arrives
      run_until_fire();
      if_id_write = 1'b0;
      pc_write    = 1'b0;
      repeat (3) cycle();
      check_eq("held_busy", {31'd0, fetch_busy}, 32'd0);
      check_eq("held_pending", sb.size(), 32'd1);
      if_id_write = 1'b1;
      pc_write    = 1'b1;
      cycle();
      check_eq("held_released", sb.size(), 32'd0);

      // flush while waiting, late response dropped
      mem_delay = 3;
      force_en  = 1'b1;
      force_val = 32'hDEAD_BEEF;
      run_until_fire();
      flush_to(32'h0000_0100);
      check_eq("drop_busy", {31'd0, fetch_busy}, 32'd1);
      mem_delay = 1;
      run_until_fire();
      check_eq("redirect_addr", fired_addr, 32'h0000_0100);
      force_en = 1'b0;

      // flush coinciding with the response
      mem_delay = 2;
      run_until_fire();
      cycle();
      flush_to(32'h0000_0100);
      check_eq("flush_rv_busy", {31'd0, fetch_busy}, 32'd0);
      mem_delay = 1;
      cycle();
      check_eq("flush_rv_req", {31'd0, fired}, 32'd1);
      check_eq("flush_rv_addr", fired_addr, 32'h0000_0100);

      // misaligned target and address wrap
      flush_to(32'h0000_0103);
      run_until_fire();
      check_eq("align_addr", fired_addr, 32'h0000_0100);
      flush_to(32'hFFFF_FFFC);
      run_until_fire();
      check_eq("top_addr", fired_addr, 32'hFFFF_FFFC);
      run_until_fire();
      check_eq("wrap_addr", fired_addr, 32'h0000_0000);

      // repeated flush while draining
      mem_delay = 4;
      run_until_fire();
      flush_to(32'h0000_0200);
      flush_to(32'h0000_0300);
      check_eq("dbl_drop_busy", {31'd0, fetch_busy}, 32'd1);
      mem_delay = 1;
      run_until_fire();
      check_eq("dbl_flush_addr", fired_addr, 32'h0000_0300);

      // reset mid-transaction
      run_until_fire();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      run_until_fire();
      check_eq("post_rst_addr", fired_addr, RST_PC);

      // counter scenario: five fetches and a flush
      repeat (9) cycle();
      flush_to(32'h0000_0040);
      repeat (4) cycle();
      check_eq("sb_empty", sb.size(), 32'd0);
      check_eq("five_fetches", n_fetch >= 5, 32'd1);
`ifdef FETCH_PERF_CNT_EN
      check_eq("perf_fetch", perf_fetch_count, n_fetch);
      check_eq("perf_bubble", perf_bubble_count, n_bubble);
`else
      check_eq("perf_fetch_off", perf_fetch_count, 32'd0);
      check_eq("perf_bubble_off", perf_bubble_count, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
